// File: rtl/vmem_arbiter.sv
// vmem_arbiter: single-port frame-buffer arbiter between VGA scanout
// prefetch (show-ahead pixel FIFO) and a host write port.
module vmem_arbiter #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              frame_start_i,
  input  logic              pix_ready_i,
  output logic              pix_valid_o,
  output logic [DATA_W-1:0] pix_data_o,
  output logic              underrun_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int TOTAL = H_RES * V_RES;
  localparam int SW    = ADDR_W + 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  localparam logic [SW-1:0] TOTAL_C = SW'(TOTAL);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LOW_C   = CW'(LOW_WATER);

  logic [SW-1:0]     scan_q, scan_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic              pend_q, pend_d;
  logic              und_q, und_d;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];

  logic [CW-1:0] occ;
  logic          urgent, space, scan_left;
  logic          live, wr_ok;
  logic          rd_gnt, wr_gnt;
  logic          push, pop;

  // Occupancy counts the in-flight read so the FIFO can never overflow.
  assign occ       = cnt_q + CW'(pend_q);
  assign urgent    = occ < LOW_C;
  assign space     = occ < DEPTH_C;
  assign scan_left = scan_q < TOTAL_C;
  assign live      = reset_i & ~frame_start_i;
  assign wr_ok     = {1'b0, wr_addr_i} < TOTAL_C;

  // Fixed priority: urgent refill, host write, opportunistic refill.
  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    priority case (1'b1)
      ~live:                        ;
      urgent && space && scan_left: rd_gnt = 1'b1;
      wr_req_i:                     wr_gnt = 1'b1;
      space && scan_left:           rd_gnt = 1'b1;
      default:                      ;
    endcase
  end

  assign mem_en_o    = rd_gnt | (wr_gnt & wr_ok);
  assign mem_we_o    = wr_gnt & wr_ok;
  assign mem_addr_o  = wr_gnt ? wr_addr_i : scan_q[ADDR_W-1:0];
  assign mem_wdata_o = wr_data_i;
  assign wr_ack_o    = wr_gnt;

  assign pix_valid_o = cnt_q != '0;
  assign pix_data_o  = pix_valid_o ? fifo_q[rptr_q] : '0;
  assign underrun_o  = und_q;

  assign push = pend_q;
  assign pop  = pix_ready_i & pix_valid_o;

  // Next state; frame_start flushes and discards the in-flight read.
  always_comb begin
    scan_d = scan_q;
    cnt_d  = cnt_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    pend_d = rd_gnt;
    und_d  = und_q;
    if (frame_start_i) begin
      scan_d = '0;
      cnt_d  = '0;
      rptr_d = '0;
      wptr_d = '0;
      pend_d = 1'b0;
      und_d  = 1'b0;
    end else begin
      if (rd_gnt) scan_d = scan_q + SW'(1);
      if (push)   wptr_d = wptr_q + PW'(1);
      if (pop)    rptr_d = rptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (pix_ready_i && !pix_valid_o) und_d = 1'b1;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      scan_q <= '0;
      cnt_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      pend_q <= 1'b0;
      und_q  <= 1'b0;
    end else begin
      scan_q <= scan_d;
      cnt_q  <= cnt_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      pend_q <= pend_d;
      und_q  <= und_d;
    end
  end

  // Pixel storage; read data lands the cycle after its read issued.
  always_ff @(posedge clock_i) begin
    if (reset_i && !frame_start_i && push) begin
      fifo_q[wptr_q] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter: directed and randomized checks of vmem_arbiter
// against a queue-based reference model and frame-buffer array.
module tb_vmem_arbiter;

  localparam int HR    = 16;
  localparam int VR    = 4;
  localparam int TOTAL = HR * VR;
  localparam int AW    = 19;
  localparam int DW    = 24;
  localparam int D     = 8;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          rst_n, fs, prdy, wreq;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata, rdata;
  logic          pv, und, wack, men, mwe;
  logic [DW-1:0] pd, mwd;
  logic [AW-1:0] maddr;

  vmem_arbiter #(
    .H_RES(HR), .V_RES(VR), .ADDR_W(AW), .DATA_W(DW),
    .FIFO_DEPTH(D), .LOW_WATER(LW)
  ) dut (
    .clock_i(clk), .reset_i(rst_n), .frame_start_i(fs),
    .pix_ready_i(prdy), .pix_valid_o(pv), .pix_data_o(pd),
    .underrun_o(und), .wr_req_i(wreq), .wr_addr_i(waddr),
    .wr_data_i(wdata), .wr_ack_o(wack), .mem_en_o(men),
    .mem_we_o(mwe), .mem_addr_o(maddr), .mem_wdata_o(mwd),
    .mem_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [DW-1:0] fb [TOTAL];
  logic [DW-1:0] mq [$];
  int            m_scan;
  bit            m_pend, m_und;
  logic [DW-1:0] m_pdata;

  bit            e_rd, e_wr, e_en, e_we, e_ack, e_pv, e_und;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_pd;

  // Expected outputs for the current inputs, from the arbitration rules.
  task automatic prep();
    int occ;
    bit left, inr;
    #1;
    occ  = mq.size() + int'(m_pend);
    left = m_scan < TOTAL;
    e_rd = 0;
    e_wr = 0;
    if (rst_n && !fs) begin
      if (occ < LW && occ < D && left) e_rd = 1;
      else if (wreq) e_wr = 1;
      else if (occ < D && left) e_rd = 1;
    end
    inr    = int'(waddr) < TOTAL;
    e_ack  = e_wr;
    e_we   = e_wr && inr;
    e_en   = e_rd || e_we;
    e_addr = e_rd ? AW'(m_scan) : waddr;
    e_pv   = mq.size() != 0;
    e_pd   = e_pv ? mq[0] : '0;
    e_und  = m_und;
  endtask

  // Memory responds to the DUT; the model advances one clock.
  task automatic adv();
    logic [DW-1:0] rnext;
    rnext = DW'($urandom);
    if (men && !mwe && int'(maddr) < TOTAL) rnext = fb[int'(maddr)];
    if (!rst_n || fs) begin
      mq.delete();
      m_scan = 0;
      m_pend = 0;
      m_und  = 0;
    end else begin
      if (prdy && mq.size() == 0) m_und = 1;
      if (prdy && mq.size() != 0) void'(mq.pop_front());
      if (m_pend) mq.push_back(m_pdata);
      m_pend = e_rd;
      if (e_rd) begin
        m_pdata = fb[m_scan];
        m_scan++;
      end
    end
    if (men && mwe && int'(maddr) < TOTAL) fb[int'(maddr)] = mwd;
    @(posedge clk);
    @(negedge clk);
    rdata = rnext;
  endtask

  task automatic test_reset();
    rst_n = 0; fs = 0; prdy = 1; wreq = 1; waddr = 5; wdata = 24'h123456;
    adv();
    prep();
    nvec++; if (men !== 1'b0) begin nerr++; $display("FAIL rst_en got %b want 0", men); end
    nvec++; if (wack !== 1'b0) begin nerr++; $display("FAIL rst_ack got %b want 0", wack); end
    nvec++; if (pv !== 1'b0) begin nerr++; $display("FAIL rst_pv got %b want 0", pv); end
    nvec++; if (pd !== '0) begin nerr++; $display("FAIL rst_pd got %h want 0", pd); end
    nvec++; if (und !== 1'b0) begin nerr++; $display("FAIL rst_und got %b want 0", und); end
    adv();
    rst_n = 1; wreq = 0; prdy = 0;
    prep();
    nvec++; if (men !== 1'b1 || mwe !== 1'b0) begin nerr++; $display("FAIL rst_rd0 got en=%b we=%b want 1 0", men, mwe); end
    nvec++; if (maddr !== '0) begin nerr++; $display("FAIL rst_addr got %0d want 0", maddr); end
    adv();
  endtask

  task automatic test_fill();
    fs = 1; prdy = 0; wreq = 0;
    prep();
    nvec++; if (men !== 1'b0) begin nerr++; $display("FAIL fill_fs got %b want 0", men); end
    adv();
    fs = 0;
    for (int i = 0; i < 12; i++) begin
      prep();
      nvec++; if (men !== (i < 8)) begin nerr++; $display("FAIL fill_en[%0d] got %b want %b", i, men, i < 8); end
      if (i < 8) begin
        nvec++; if (maddr !== AW'(i)) begin nerr++; $display("FAIL fill_addr[%0d] got %0d want %0d", i, maddr, i); end
      end
      nvec++; if (pv !== (i >= 2)) begin nerr++; $display("FAIL fill_pv[%0d] got %b want %b", i, pv, i >= 2); end
      if (i >= 2) begin
        nvec++; if (pd !== fb[0]) begin nerr++; $display("FAIL fill_pd[%0d] got %h want %h", i, pd, fb[0]); end
      end
      adv();
    end
  endtask

  task automatic test_drain_write();
    int acks = 0;
    prdy = 1;
    for (int i = 0; i < 24; i++) begin
      if (!wreq) begin
        wreq  = 1;
        waddr = AW'($urandom_range(20, TOTAL - 1));
        wdata = DW'($urandom);
      end
      prep();
      nvec++; if (wack !== e_ack) begin nerr++; $display("FAIL dw_ack[%0d] got %b want %b", i, wack, e_ack); end
      nvec++; if (men !== e_en || mwe !== e_we) begin nerr++; $display("FAIL dw_op[%0d] got %b%b want %b%b", i, men, mwe, e_en, e_we); end
      if (e_en) begin
        nvec++; if (maddr !== e_addr) begin nerr++; $display("FAIL dw_addr[%0d] got %0d want %0d", i, maddr, e_addr); end
      end
      if (e_we) begin
        nvec++; if (mwd !== wdata) begin nerr++; $display("FAIL dw_wdata[%0d] got %h want %h", i, mwd, wdata); end
      end
      nvec++; if (pd !== e_pd) begin nerr++; $display("FAIL dw_pd[%0d] got %h want %h", i, pd, e_pd); end
      if (wack) acks++;
      adv();
      if (e_ack) wreq = 0;
    end
    nvec++; if (acks !== D - LW + 1) begin nerr++; $display("FAIL dw_nacks got %0d want %0d", acks, D - LW + 1); end
    wreq = 0;
  endtask

  task automatic test_underrun();
    fs = 1; prdy = 1;
    prep();
    nvec++; if (men !== 1'b0) begin nerr++; $display("FAIL ur_fs got %b want 0", men); end
    adv();
    fs = 0;
    prep();
    nvec++; if (und !== 1'b0) begin nerr++; $display("FAIL ur_ign got %b want 0", und); end
    nvec++; if (pv !== 1'b0 || pd !== '0) begin nerr++; $display("FAIL ur_empty got %b %h want 0 0", pv, pd); end
    adv();
    prdy = 0;
    for (int i = 0; i < 4; i++) begin
      prep();
      nvec++; if (und !== 1'b1) begin nerr++; $display("FAIL ur_sticky[%0d] got %b want 1", i, und); end
      adv();
    end
    fs = 1;
    prep();
    adv();
    fs = 0;
    prep();
    nvec++; if (und !== 1'b0) begin nerr++; $display("FAIL ur_clear got %b want 0", und); end
    adv();
  endtask

  task automatic test_flush();
    prdy = 0; wreq = 0;
    for (int i = 0; i < 20 && mq.size() < 4; i++) begin
      prep();
      adv();
    end
    prep();
    nvec++; if (pv !== 1'b1) begin nerr++; $display("FAIL fl_pre got %b want 1", pv); end
    fs = 1;
    prep();
    adv();
    fs = 0;
    prep();
    nvec++; if (pv !== 1'b0) begin nerr++; $display("FAIL fl_empty got %b want 0", pv); end
    nvec++; if (men !== 1'b1 || maddr !== '0) begin nerr++; $display("FAIL fl_rd0 got en=%b addr=%0d want 1 0", men, maddr); end
    adv();
    prep();
    nvec++; if (pv !== 1'b0) begin nerr++; $display("FAIL fl_stale got %b want 0", pv); end
    adv();
    prep();
    nvec++; if (pv !== 1'b1 || pd !== fb[0]) begin nerr++; $display("FAIL fl_first got %b %h want 1 %h", pv, pd, fb[0]); end
    adv();
  endtask

  task automatic test_oob();
    prdy = 0; wreq = 0;
    for (int i = 0; i < 10; i++) begin
      prep();
      adv();
    end
    wreq = 1; waddr = AW'(TOTAL); wdata = DW'($urandom);
    prep();
    nvec++; if (wack !== 1'b1) begin nerr++; $display("FAIL oob_ack got %b want 1", wack); end
    nvec++; if (men !== 1'b0) begin nerr++; $display("FAIL oob_en got %b want 0", men); end
    adv();
    wreq = 0;
    prep();
    nvec++; if (wack !== 1'b0) begin nerr++; $display("FAIL oob_once got %b want 0", wack); end
    adv();
  endtask

  task automatic test_eof();
    bit saw_last = 0;
    bit done;
    prdy = 1; wreq = 0;
    for (int i = 0; i < 100; i++) begin
      prep();
      nvec++; if (men !== e_en) begin nerr++; $display("FAIL eof_en[%0d] got %b want %b", i, men, e_en); end
      if (e_en) begin
        nvec++; if (maddr !== e_addr) begin nerr++; $display("FAIL eof_addr[%0d] got %0d want %0d", i, maddr, e_addr); end
      end
      nvec++; if (pd !== e_pd) begin nerr++; $display("FAIL eof_pd[%0d] got %h want %h", i, pd, e_pd); end
      if (men && !mwe && maddr == AW'(TOTAL - 1)) saw_last = 1;
      adv();
    end
    nvec++; if (saw_last !== 1'b1) begin nerr++; $display("FAIL eof_last got %b want 1", saw_last); end
    for (int k = 0; k < 6; k++) begin
      wreq = 1; waddr = AW'($urandom_range(0, TOTAL - 1)); wdata = DW'($urandom);
      prep();
      nvec++; if (wack !== 1'b1 || men !== 1'b1 || mwe !== 1'b1) begin nerr++; $display("FAIL eof_b2b[%0d] got %b%b%b want 111", k, wack, men, mwe); end
      nvec++; if (maddr !== waddr || mwd !== wdata) begin nerr++; $display("FAIL eof_wr[%0d] got %0d %h want %0d %h", k, maddr, mwd, waddr, wdata); end
      adv();
    end
    fs = 1;
    prep();
    nvec++; if (wack !== 1'b0 || men !== 1'b0) begin nerr++; $display("FAIL eof_fs got %b %b want 0 0", wack, men); end
    adv();
    fs = 0; prdy = 0;
    prep();
    nvec++; if (wack !== 1'b0 || men !== 1'b1 || maddr !== '0) begin nerr++; $display("FAIL eof_rd0 got ack=%b en=%b addr=%0d want 0 1 0", wack, men, maddr); end
    adv();
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      prep();
      nvec++; if (wack !== e_ack) begin nerr++; $display("FAIL eof_pend[%0d] got %b want %b", i, wack, e_ack); end
      done = e_ack;
      adv();
    end
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL eof_pend_timeout got %b want 1", done); end
    wreq = 0;
  endtask

  task automatic test_random();
    bit acked = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 499) != 0;
      fs    = $urandom_range(0, 199) == 0;
      prdy  = $urandom_range(0, 9) < 6;
      if (acked || !rst_n) wreq = 0;
      if (rst_n && !wreq && $urandom_range(0, 3) == 0) begin
        wreq  = 1;
        waddr = AW'($urandom_range(0, TOTAL + 7));
        wdata = DW'($urandom);
      end
      prep();
      nvec++; if (men !== e_en || mwe !== e_we) begin nerr++; $display("FAIL rnd_op[%0d] got %b%b want %b%b", i, men, mwe, e_en, e_we); end
      nvec++; if (wack !== e_ack) begin nerr++; $display("FAIL rnd_ack[%0d] got %b want %b", i, wack, e_ack); end
      if (e_en) begin
        nvec++; if (maddr !== e_addr) begin nerr++; $display("FAIL rnd_addr[%0d] got %0d want %0d", i, maddr, e_addr); end
      end
      if (e_we) begin
        nvec++; if (mwd !== wdata) begin nerr++; $display("FAIL rnd_wdata[%0d] got %h want %h", i, mwd, wdata); end
      end
      nvec++; if (pv !== e_pv || pd !== e_pd) begin nerr++; $display("FAIL rnd_pix[%0d] got %b %h want %b %h", i, pv, pd, e_pv, e_pd); end
      nvec++; if (und !== e_und) begin nerr++; $display("FAIL rnd_und[%0d] got %b want %b", i, und, e_und); end
      acked = e_ack;
      adv();
    end
  endtask

  initial begin
    for (int a = 0; a < TOTAL; a++) fb[a] = DW'($urandom);
    m_scan = 0; m_pend = 0; m_und = 0; m_pdata = '0;
    rst_n = 0; fs = 0; prdy = 0; wreq = 0;
    waddr = '0; wdata = '0; rdata = '0;
    test_reset();
    test_fill();
    test_drain_write();
    test_underrun();
    test_flush();
    test_oob();
    test_eof();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
